// File: rtl/eth_phy_10g_tx_gearbox.sv
//------------------------------------------------------------------------------
// Module   : eth_phy_10g_tx_gearbox
// Brief    : 10GBASE-R TX gearbox. Repacks 66-bit {payload, sync header}
//            blocks into a continuous 64-bit word stream (bit 0 first).
//            32 blocks map onto 33 words, so one cycle in 33 is a flush
//            cycle during which upstream is held off.
// Options  : `define ETH_PHY_TX_GEARBOX_CHECK_EN enables the sticky
//            status_err protocol checker (underflow / ignored back-pressure).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module eth_phy_10g_tx_gearbox #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  status_err
);

  // Block width and the working window width. The window only needs
  // 128 bits: with at most 62 residual bits plus a 66-bit block the
  // highest populated bit is 127.
  localparam int         c_BLK_W     = DATA_WIDTH + HDR_WIDTH;
  localparam int         c_WIN_W     = 2 * DATA_WIDTH;
  localparam logic [5:0] c_SEQ_FLUSH = 6'd32;

  // Only the 64/2 geometry is meaningful for 10GBASE-R; stop elaboration
  // on anything else.
  generate
    if (DATA_WIDTH != 64) begin : g_bad_data_width
      $error("eth_phy_10g_tx_gearbox: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
      $error("eth_phy_10g_tx_gearbox: HDR_WIDTH must be 2");
    end
  endgenerate

  logic [5:0]            r_seq;
  logic [DATA_WIDTH-1:0] r_res;
  logic [DATA_WIDTH-1:0] r_out;

  logic [5:0]            w_seq_nxt;
  logic [DATA_WIDTH-1:0] w_res_nxt;
  logic [DATA_WIDTH-1:0] w_out_nxt;
  logic                  w_flush;
  logic [c_BLK_W-1:0]    w_blk;
  logic [c_WIN_W-1:0]    w_blk_shift;
  logic [c_WIN_W-1:0]    w_win;
  logic [6:0]            w_shamt;

  // Flush slot: the residual holds exactly one full word and no block
  // may be taken. Ready is driven from registered state (and rst) only.
  assign w_flush  = (r_seq == c_SEQ_FLUSH);
  assign in_ready = !rst && !w_flush;
  assign out_data = r_out;

  // Next-state datapath: merge the new block above the residual bits,
  // emit the low word, keep the rest. A missing block still occupies its
  // slot as zeros so the 33-cycle cadence never slips.
  always_comb begin
    w_blk       = in_valid ? {in_data, in_hdr} : '0;
    w_shamt     = {r_seq, 1'b0};
    w_blk_shift = {{(c_WIN_W - c_BLK_W){1'b0}}, w_blk} << w_shamt;
    w_win       = {{DATA_WIDTH{1'b0}}, r_res} | w_blk_shift;
    w_seq_nxt   = r_seq + 6'd1;
    w_res_nxt   = w_win[c_WIN_W-1:DATA_WIDTH];
    w_out_nxt   = w_win[DATA_WIDTH-1:0];
    if (w_flush) begin
      w_seq_nxt = 6'd0;
      w_res_nxt = '0;
      w_out_nxt = r_res;
    end
  end

  // State registers; reset drops any partially assembled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= 6'd0;
      r_res <= '0;
      r_out <= '0;
    end else begin
      r_seq <= w_seq_nxt;
      r_res <= w_res_nxt;
      r_out <= w_out_nxt;
    end
  end

`ifdef ETH_PHY_TX_GEARBOX_CHECK_EN
  logic r_err;
  logic w_err_set;

  // Protocol violation: no block offered in an accept slot, or a block
  // offered while the gearbox is flushing.
  always_comb begin
    w_err_set = w_flush ? in_valid : !in_valid;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign status_err = r_err;
`else
  assign status_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
//------------------------------------------------------------------------------
// Module   : tb_eth_phy_10g_tx_gearbox
// Brief    : Directed self-checking bench for eth_phy_10g_tx_gearbox with a
//            bit-queue reference model of the serial stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_eth_phy_10g_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [1:0]  in_hdr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        status_err;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;
  bit q[$];

  eth_phy_10g_tx_gearbox #(
    .DATA_WIDTH(64),
    .HDR_WIDTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_hdr    (in_hdr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .status_err(status_err)
  );

  always #5 clk = ~clk;

`ifdef ETH_PHY_TX_GEARBOX_CHECK_EN
  localparam logic c_ERR_ON_FLUSH = 1'b1;
`else
  localparam logic c_ERR_ON_FLUSH = 1'b0;
`endif

  // Hold reset for a few edges, then release and restart the model.
  task automatic apply_reset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_hdr   = '0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    k   = 0;
    q.delete();
  endtask

  // One clock: drive inputs, note ready before the edge, advance the
  // reference stream, sample the output word after the edge.
  task automatic step(input logic v, input logic [63:0] d, input logic [1:0] h,
                      output logic rdy_obs, output logic rdy_exp,
                      output logic [63:0] out_obs, output logic [63:0] out_exp);
    logic [65:0] blk;
    in_valid = v;
    in_data  = d;
    in_hdr   = h;
    #1;
    rdy_obs = in_ready;
    rdy_exp = ((k % 33) != 32);
    if (rdy_exp) begin
      blk = v ? {d, h} : 66'b0;
      for (int i = 0; i < 66; i++) q.push_back(blk[i]);
    end
    out_exp = '0;
    for (int i = 0; i < 64; i++) begin
      if (q.size() > 0) out_exp[i] = q.pop_front();
    end
    @(posedge clk);
    #1;
    out_obs = out_data;
    k++;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_1111;
    in_hdr   = 2'b01;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (out_data !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_out_data: got %h expected %h", out_data, 64'h0);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    n_checks++;
    if (status_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_status_err: got %b expected 0", status_err);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    k        = 0;
    q.delete();
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL release_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic ro, re;
    logic [63:0] oo, oe;
    step(1'b1, 64'h0, 2'b01, ro, re, oo, oe);
    n_checks++;
    if (ro !== 1'b1) begin
      n_errors++;
      $display("FAIL basic0_in_ready: got %b expected 1", ro);
    end
    n_checks++;
    if (oo !== 64'h0000_0000_0000_0001) begin
      n_errors++;
      $display("FAIL basic0_out: got %h expected %h", oo, 64'h0000_0000_0000_0001);
    end
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, ro, re, oo, oe);
    n_checks++;
    if (oo !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      n_errors++;
      $display("FAIL basic1_out: got %h expected %h", oo, 64'hFFFF_FFFF_FFFF_FFF8);
    end
  endtask

  task automatic test_continuous();
    logic ro, re, v;
    logic [63:0] oo, oe, d;
    int low_cnt;
    int low_at[$];
    apply_reset(2);
    low_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      v = ((c % 33) != 32);
      d = {$urandom, $urandom};
      step(v, d, 2'($urandom_range(0, 3)), ro, re, oo, oe);
      if (ro === 1'b0) begin
        low_cnt++;
        low_at.push_back(c);
      end
      n_checks++;
      if (ro !== re) begin
        n_errors++;
        $display("FAIL cont_in_ready cycle %0d: got %b expected %b", c, ro, re);
      end
      n_checks++;
      if (oo !== oe) begin
        n_errors++;
        $display("FAIL cont_out cycle %0d: got %h expected %h", c, oo, oe);
      end
    end
    n_checks++;
    if (low_cnt != 3 || low_at[0] != 32 || low_at[1] != 65 || low_at[2] != 98) begin
      n_errors++;
      $display("FAIL cont_ready_low_count: got %0d low cycles expected 3 at 32/65/98", low_cnt);
    end
  endtask

  task automatic test_flush();
    logic ro, re;
    logic [63:0] oo, oe;
    apply_reset(1);
    for (int c = 0; c < 32; c++) begin
      step(1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 2'b01, ro, re, oo, oe);
      n_checks++;
      if (oo !== oe) begin
        n_errors++;
        $display("FAIL flush_fill_out word %0d: got %h expected %h", c, oo, oe);
      end
    end
    step(1'b0, 64'h0, 2'b00, ro, re, oo, oe);
    n_checks++;
    if (ro !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_in_ready: got %b expected 0", ro);
    end
    n_checks++;
    if (oo !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      n_errors++;
      $display("FAIL flush_word33: got %h expected %h", oo, 64'hA5A5_A5A5_A5A5_A5A5);
    end
    step(1'b1, 64'h0, 2'b01, ro, re, oo, oe);
    n_checks++;
    if (ro !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_wrap_ready: got %b expected 1", ro);
    end
    n_checks++;
    if (oo !== 64'h0000_0000_0000_0001) begin
      n_errors++;
      $display("FAIL flush_wrap_out: got %h expected %h", oo, 64'h1);
    end
  endtask

  task automatic test_mid_reset();
    logic ro, re;
    logic [63:0] oo, oe;
    apply_reset(1);
    for (int c = 0; c < 17; c++) begin
      step(1'b1, {$urandom, $urandom}, 2'b10, ro, re, oo, oe);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_data !== 64'h0) begin
      n_errors++;
      $display("FAIL midrst_out: got %h expected %h", out_data, 64'h0);
    end
    rst = 1'b0;
    k   = 0;
    q.delete();
    step(1'b1, 64'h1234_5678_9ABC_DEF0, 2'b11, ro, re, oo, oe);
    n_checks++;
    if (ro !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_restart_ready: got %b expected 1", ro);
    end
    n_checks++;
    if (oo !== 64'h48D1_59E2_6AF3_7BC3) begin
      n_errors++;
      $display("FAIL midrst_restart_out: got %h expected %h", oo, 64'h48D1_59E2_6AF3_7BC3);
    end
    step(1'b1, 64'h0, 2'b00, ro, re, oo, oe);
    n_checks++;
    if (oo !== 64'h0) begin
      n_errors++;
      $display("FAIL midrst_second_out: got %h expected %h", oo, 64'h0);
    end
  endtask

  task automatic test_status_err();
    logic ro, re;
    logic [63:0] oo, oe;
    apply_reset(1);
    for (int c = 0; c < 32; c++) begin
      step(1'b1, {$urandom, $urandom}, 2'b01, ro, re, oo, oe);
    end
    n_checks++;
    if (status_err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_before_flush: got %b expected 0", status_err);
    end
    step(1'b1, 64'hFFFF_0000_FFFF_0000, 2'b10, ro, re, oo, oe);
    n_checks++;
    if (oo !== oe) begin
      n_errors++;
      $display("FAIL err_flush_out: got %h expected %h", oo, oe);
    end
    n_checks++;
    if (status_err !== c_ERR_ON_FLUSH) begin
      n_errors++;
      $display("FAIL err_after_flush: got %b expected %b", status_err, c_ERR_ON_FLUSH);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, {$urandom, $urandom}, 2'b01, ro, re, oo, oe);
      n_checks++;
      if (status_err !== c_ERR_ON_FLUSH) begin
        n_errors++;
        $display("FAIL err_sticky cycle %0d: got %b expected %b", c, status_err, c_ERR_ON_FLUSH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_flush();
    test_mid_reset();
    test_status_err();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
